down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
Synchronous, loadable, programmable down-counter with terminal-count pulse, one-shot and auto-reload modes. It is the counting-down counterpart of the team's ripple up-counter and serves as the interval/timeout generator for the lab designs. All state changes on the rising clk edge; no derived or rippled clocks.

Parameters:
WIDTH, 4, counter and reload-value width in bits (legal range 2..32).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
load  input  1  synchronous load strobe; captures load_val
load_val  input  WIDTH  start/reload value
en  input  1  count enable; count decrements only when en=1
mode  input  1  0 = one-shot, 1 = auto-reload
count  output  WIDTH  current counter value (registered)
tc  output  1  terminal-count pulse, high for exactly one clk cycle (registered)
busy  output  1  high while in RUN (registered)

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, independent of clk): count=0, reload register=0, tc=0, busy=0, state=IDLE. Release is synchronous to the next rising clk edge; the first load is honoured on the first edge after release.
- States:
  - IDLE: after reset or load of 0.
  - RUN: counting.
  - DONE: one-shot expired.
- busy=1 only in RUN.
- Priority per edge:
  1. load
  2. terminal event
  3. decrement
  4. hold
- load=1 (any state, any en, any mode):
  - reload_reg<=load_val; count<=load_val; tc<=0.
  - load_val!=0: state<=RUN; busy=1 from the next cycle.
  - load_val==0: state<=IDLE, no tc.
- RUN, en=1, count>1: count<=count-1, tc<=0.
- RUN, en=1, count==1 (terminal event): tc<=1 for one cycle.
  - mode=0: count<=0, state<=DONE.
  - mode=1: count<=reload_reg, stay in RUN.
- Timing:
  - One-shot of N needs exactly N enabled cycles from load to tc visible.
  - Auto-reload period is exactly N enabled cycles between tc pulses.
- RUN, en=0: count and state hold; tc<=0. Stalls stretch the period but never drop or double a tc.
- IDLE/DONE: count holds (0 in DONE, last loaded value in IDLE); no decrement, no underflow, tc=0 regardless of en.
- mode is sampled at the terminal edge only. A change mid-run takes effect at the next terminal event.
- Load coincident with a terminal event: load wins, tc=0, new value loaded.
- tc never asserts on two consecutive cycles except in auto-reload with reload value 1 and en held high, where tc stays high continuously and count stays 1.
- Arithmetic:
  - All WIDTH-bit unsigned.
  - load_val = 2^WIDTH-1 is legal.
  - count never wraps from 0 to all-ones.
- Reset asserted mid-RUN: outputs go to reset values immediately (asynchronously), with no tc glitch. After release the block stays in IDLE until the next load.

Test Plan:
- Reset: rst_n=0 mid-cycle with count=7 and busy=1 → count=0, tc=0, busy=0 before the next clk edge; after release with no load, count stays 0 for 10 cycles.
- One-shot, WIDTH=4: load_val=5, mode=0, en=1 → count 5,4,3,2,1,0; tc high only in the cycle count becomes 0 (5th edge after load); busy drops with tc; count holds 0 afterwards.
- Auto-reload: load_val=3, mode=1, en=1 for 12 cycles → count 3,2,1,3,2,1,...; tc high on every 3rd edge (4 pulses); busy stays 1.
- Enable gating: load_val=4, mode=0, en toggling 1,0,0,1,1,0,1 → tc after exactly 4 enabled cycles; count constant during every en=0 cycle.
- Load collision: auto-reload at count=1, en=1, load=1 with load_val=9 on the same edge → count=9, tc=0; the next tc comes 9 enabled cycles later.
- Edge values:
  - load_val=0 → state IDLE, busy=0, no tc.
  - load_val=15, mode=0 → tc after 15 cycles, count never wraps.
  - load_val=1, mode=1, en=1 → tc continuously high.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable down-counter: terminal-count pulse, one-shot or auto-reload; outputs registered, load/tc visible one edge later.
// No backpressure: en=0 stalls the count without losing or repeating a terminal pulse.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= (state_d == RUN);
    end
  end

  // Load beats the terminal event, which beats a plain decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      reload_d = load_val;
      count_d  = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (count_q == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (mode) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    count = count_q;
    tc    = tc_q;
    busy  = busy_q;
  end

endmodule
